// File: rtl/spi_ctrl_pkg.sv
// Shared types and default constants for the SPI transfer sequencer.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD
    } spi_state_e;

    localparam int unsigned DEF_CS_SETUP = 2;
    localparam int unsigned DEF_CS_HOLD  = 2;
    localparam int unsigned DEF_GAP      = 1;
    localparam int unsigned SPI_BYTE_W   = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_ctrl_timer.sv
// Loadable down-counter shared by the CS setup, inter-byte gap and CS hold phases.
module spi_ctrl_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences a register-issued start into a chip-select framed multi-byte SPI burst.
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SS   = 4,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned CS_SETUP = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
    parameter int unsigned GAP      = DEF_GAP
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       cfg_start,
    input  logic [$clog2(NUM_SS)-1:0]  cfg_ss_sel,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       abort,
    input  logic                       tx_valid,
    input  logic [SPI_BYTE_W-1:0]      tx_data,
    output logic                       tx_ready,
    output logic                       rx_valid,
    output logic [SPI_BYTE_W-1:0]      rx_data,
    input  logic                       rx_ready,
    output logic                       eng_start,
    output logic [SPI_BYTE_W-1:0]      eng_tx,
    input  logic                       eng_done,
    input  logic [SPI_BYTE_W-1:0]      eng_rx,
    output logic [NUM_SS-1:0]          ss_n,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [LEN_W-1:0]           bytes_left
);

    localparam int unsigned TMR_MAX = max3(CS_SETUP, CS_HOLD, GAP);
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    spi_state_e                 state, state_d;
    logic [$clog2(NUM_SS)-1:0]  sel_q;
    logic                       abort_pend;

    logic                       tmr_load;
    logic [TMR_W-1:0]           tmr_val;
    logic                       tmr_zero;

    logic                       start_acc;
    logic                       load_go;
    logic                       rx_cap;
    logic                       dec_left;
    logic                       set_abort;
    logic                       finish;

    spi_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= ST_IDLE;
        else          state <= state_d;
    end

    // Next-state decode plus the per-cycle strobes that steer the datapath.
    always_comb begin
        state_d   = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tx_ready  = 1'b0;
        start_acc = 1'b0;
        load_go   = 1'b0;
        rx_cap    = 1'b0;
        dec_left  = 1'b0;
        set_abort = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    start_acc = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(CS_SETUP - 1);
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP, ST_GAP: begin
                if (abort) begin
                    set_abort = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(CS_HOLD - 1);
                    state_d   = ST_HOLD;
                end else if (tmr_zero) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    set_abort = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(CS_HOLD - 1);
                    state_d   = ST_HOLD;
                end else if (tx_valid && !rx_valid) begin
                    tx_ready = 1'b1;
                    load_go  = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    if (abort || abort_pend) begin
                        set_abort = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(CS_HOLD - 1);
                        state_d   = ST_HOLD;
                    end else begin
                        rx_cap = 1'b1;
                        if (bytes_left == '0) begin
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(CS_HOLD - 1);
                            state_d  = ST_HOLD;
                        end else begin
                            dec_left = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(GAP - 1);
                            state_d  = ST_GAP;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst bookkeeping, engine handshake and RX holding register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sel_q      <= '0;
            bytes_left <= '0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            eng_start  <= 1'b0;
            eng_tx     <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            done       <= 1'b0;
        end else begin
            eng_start  <= load_go;
            done       <= finish;
            // An abort during a shift waits for the engine to finish its byte.
            abort_pend <= (state == ST_SHIFT) && !eng_done && (abort_pend || abort);
            if (start_acc) begin
                sel_q      <= cfg_ss_sel;
                bytes_left <= cfg_len;
                aborted    <= 1'b0;
            end
            if (set_abort) aborted <= 1'b1;
            if (dec_left) bytes_left <= bytes_left - LEN_W'(1);
            if (load_go) eng_tx <= tx_data;
            if (rx_cap) begin
                rx_valid <= 1'b1;
                rx_data  <= eng_rx;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Selects are decoded from state so reset deasserts them without a clock.
    always_comb begin
        ss_n = '1;
        if (state != ST_IDLE) ss_n[sel_q] = 1'b0;
    end

    assign busy = (state != ST_IDLE);

endmodule
